fir_ystream_buf: RTL and testbench

- Downstream stage of the FIR core. Consumes its output AXI-Stream (y[n] samples plus tlast) and buffers them in a small synchronous FIFO.
- Re-presents the buffered samples to the host-side AXI-Stream master with proper backpressure.
- The FIR core does not honour sm_tready, so this block also:
  - detects beats dropped while full (sticky overflow flag);
  - tracks beat and frame counts;
  - pulses frame_done when the last sample of a frame leaves.

---
 rtl/fir_stream_pkg.sv | 18 +
 rtl/fir_ystream_mem.sv | 24 ++
 rtl/fir_ystream_buf.sv | 145 ++++++++++++++
 tb/tb_fir_ystream_buf.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_stream_pkg.sv
// Shared types for the FIR output stream buffer: data width default, frame state
// encoding and the pointer-width helper.
package fir_stream_pkg;

  localparam int P_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_TAIL   = 2'b10
  } frame_state_t;

  // Keeps a 1-bit pointer legal even for the smallest FIFO.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fir_ystream_mem.sv
// Dual-port register array: synchronous write, asynchronous read.
// No reset on storage; the parent owns validity and registers the read data.
module fir_ystream_mem #(
  parameter int W     = 33,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fir_ystream_buf.sv
// FIR y[n] stream buffer: FIFO with registered first-word-fall-through output (1 cycle
// push-to-valid), ready backpressure, sticky overflow for beats dropped while full, frame tracking.
module fir_ystream_buf
  import fir_stream_pkg::*;
#(
  parameter int pDATA_WIDTH = P_DATA_WIDTH,
  parameter int DEPTH       = 8,
  parameter int pCNT_WIDTH  = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   clear,
  input  logic                   s_tvalid,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic                   m_tvalid,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic [$clog2(DEPTH):0] level,
  output logic [pCNT_WIDTH-1:0]  beat_cnt,
  output logic [pCNT_WIDTH-1:0]  frame_cnt,
  output logic                   frame_done,
  output logic                   overflow
);

  localparam int AW = ptr_width(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int EW = pDATA_WIDTH + 1;

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  out_vld_q, out_vld_d;
  logic [EW-1:0]         out_dat_q, out_dat_d;
  logic [pCNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d, frame_cnt_q, frame_cnt_d;
  logic                  frame_done_q, frame_done_d;
  logic                  overflow_q, overflow_d;
  logic                  rdy_en_q;
  frame_state_t          state_q, state_d;
  logic                  push, pop, bypass;
  logic [EW-1:0]         mem_rdata;

  // rdy_en_q holds ready low during reset and releases it one cycle after.
  assign s_tready = rdy_en_q && (level_q != LW'(DEPTH)) && !clear;
  assign push     = s_tvalid && s_tready;
  assign pop      = out_vld_q && m_tready;
  // The next head is the beat arriving this cycle, not yet readable from the array.
  assign bypass   = push && ((level_q == '0) || ((level_q == LW'(1)) && pop));

  fir_ystream_mem #(.W(EW), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk_i   (axis_clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i ({s_tlast, s_tdata}),
    .raddr_i (rd_ptr_d),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (!push && pop) level_d = level_q - LW'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    out_dat_d    = out_dat_q;
    out_vld_d    = (level_d != '0);
    frame_done_d = pop && out_dat_q[EW-1];
    beat_cnt_d   = beat_cnt_q + pCNT_WIDTH'(push);
    frame_cnt_d  = frame_cnt_q + pCNT_WIDTH'(frame_done_d);
    overflow_d   = overflow_q || (s_tvalid && !s_tready && !clear);

    if (out_vld_d) out_dat_d = bypass ? {s_tlast, s_tdata} : mem_rdata;

    case (state_q)
      // A single-beat frame goes straight to TAIL so its tlast pop can close it.
      ST_IDLE:   if (push) state_d = s_tlast ? ST_TAIL : ST_ACTIVE;
      ST_ACTIVE: if (push && s_tlast) state_d = ST_TAIL;
      ST_TAIL: begin
        if (push && s_tlast)             state_d = ST_TAIL;
        else if (pop && out_dat_q[EW-1]) state_d = push ? ST_ACTIVE : ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase

    if (clear) begin
      state_d      = ST_IDLE;
      out_vld_d    = 1'b0;
      frame_done_d = 1'b0;
      beat_cnt_d   = '0;
      frame_cnt_d  = '0;
      overflow_d   = 1'b0;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      out_vld_q    <= 1'b0;
      out_dat_q    <= '0;
      beat_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      rdy_en_q     <= 1'b0;
      state_q      <= ST_IDLE;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      out_vld_q    <= out_vld_d;
      out_dat_q    <= out_dat_d;
      beat_cnt_q   <= beat_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      rdy_en_q     <= 1'b1;
      state_q      <= state_d;
    end
  end

  assign m_tvalid   = out_vld_q;
  assign m_tdata    = out_dat_q[pDATA_WIDTH-1:0];
  assign m_tlast    = out_dat_q[EW-1];
  assign level      = level_q;
  assign beat_cnt   = beat_cnt_q;
  assign frame_cnt  = frame_cnt_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_fir_ystream_buf.sv
// Directed bench for fir_ystream_buf: a vector table for streaming/fill/overflow/drain,
// then hand-written sequences for push/pop at constant level, clear, back-to-back frames, reset.
module tb_fir_ystream_buf;
  import fir_stream_pkg::*;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        s_tvalid = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic        m_tready = 1'b0;
  logic [3:0]  level;
  logic [31:0] beat_cnt;
  logic [31:0] frame_cnt;
  logic        frame_done;
  logic        overflow;

  int n_chk = 0;
  int n_fail = 0;

  fir_ystream_buf #(.pDATA_WIDTH(32), .DEPTH(8), .pCNT_WIDTH(32)) dut (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .clear      (clear),
    .s_tvalid   (s_tvalid),
    .s_tdata    (s_tdata),
    .s_tlast    (s_tlast),
    .s_tready   (s_tready),
    .m_tvalid   (m_tvalid),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready),
    .level      (level),
    .beat_cnt   (beat_cnt),
    .frame_cnt  (frame_cnt),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  always #5 axis_clk = ~axis_clk;

  typedef struct {
    logic        vld;
    logic [31:0] dat;
    logic        lst;
    logic        rdy;
    logic        exp_srdy;
    logic        exp_mv;
    logic [31:0] exp_md;
    logic        exp_ml;
    int          exp_lvl;
    int          exp_beat;
    int          exp_fc;
    logic        exp_fd;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic vld, input logic [31:0] dat, input logic lst, input logic rdy,
                     input logic srdy, input logic mv, input logic [31:0] md, input logic ml,
                     input int lvl, input int beat, input int fc, input logic fd, input logic ovf);
    vec_t v;
    v = '{vld, dat, lst, rdy, srdy, mv, md, ml, lvl, beat, fc, fd, ovf};
    vecs.push_back(v);
  endtask

  task automatic cyc(input logic v, input logic [31:0] d, input logic l, input logic r);
    s_tvalid = v;
    s_tdata  = d;
    s_tlast  = l;
    m_tready = r;
    @(posedge axis_clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    s_tvalid = v.vld;
    s_tdata  = v.dat;
    s_tlast  = v.lst;
    m_tready = v.rdy;
    #1;
    chk($sformatf("v%0d s_tready", idx), s_tready, v.exp_srdy);
    @(posedge axis_clk);
    #1;
    chk($sformatf("v%0d m_tvalid", idx), m_tvalid, v.exp_mv);
    if (v.exp_mv) begin
      chk($sformatf("v%0d m_tdata", idx), m_tdata, v.exp_md);
      chk($sformatf("v%0d m_tlast", idx), m_tlast, v.exp_ml);
    end
    chk($sformatf("v%0d level", idx), level, v.exp_lvl);
    chk($sformatf("v%0d beat_cnt", idx), beat_cnt, v.exp_beat);
    chk($sformatf("v%0d frame_cnt", idx), frame_cnt, v.exp_fc);
    chk($sformatf("v%0d frame_done", idx), frame_done, v.exp_fd);
    chk($sformatf("v%0d overflow", idx), overflow, v.exp_ovf);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single frame 0x1..0x5 streamed through with m_tready=1.
    add(1, 32'h1, 0, 1,  1, 1, 32'h1, 0, 1, 1, 0, 0, 0);
    add(1, 32'h2, 0, 1,  1, 1, 32'h2, 0, 1, 2, 0, 0, 0);
    add(1, 32'h3, 0, 1,  1, 1, 32'h3, 0, 1, 3, 0, 0, 0);
    add(1, 32'h4, 0, 1,  1, 1, 32'h4, 0, 1, 4, 0, 0, 0);
    add(1, 32'h5, 1, 1,  1, 1, 32'h5, 1, 1, 5, 0, 0, 0);
    add(0, 32'h0, 0, 1,  1, 0, 32'h0, 0, 0, 5, 1, 1, 0);
    add(0, 32'h0, 0, 1,  1, 0, 32'h0, 0, 0, 5, 1, 0, 0);
    // Fill 0x10..0x17 with m_tready=0; head stays 0x10.
    for (int k = 0; k < 8; k++)
      add(1, 32'h10 + k, (k == 7), 0,  1, 1, 32'h10, 0, k + 1, 6 + k, 1, 0, 0);
    // Ninth beat while full is dropped and flagged.
    add(1, 32'hDEAD, 0, 0,  0, 1, 32'h10, 0, 8, 13, 1, 0, 1);
    // Drain exactly 8 beats in order; 0xDEAD must never appear.
    for (int k = 0; k < 8; k++)
      add(0, 32'h0, 0, 1,  (k != 0), (k < 7), 32'h11 + k, (k == 6), 7 - k, 13,
          (k == 7) ? 2 : 1, (k == 7), 1);

    // Reset state.
    #1;
    chk("rst m_tvalid", m_tvalid, 0);
    chk("rst m_tdata", m_tdata, 0);
    chk("rst s_tready", s_tready, 0);
    chk("rst level", level, 0);
    chk("rst frame_done", frame_done, 0);
    @(posedge axis_clk);
    @(posedge axis_clk);
    #1;
    axis_rst_n = 1'b1;
    #1;
    chk("post-rst s_tready low", s_tready, 0);
    cyc(0, 0, 0, 1);
    chk("post-rst s_tready high", s_tready, 1);

    foreach (vecs[i]) apply(vecs[i], i);

    // Push and pop together at level 3 for 10 cycles.
    cyc(1, 32'h20, 0, 0);
    cyc(1, 32'h21, 0, 0);
    cyc(1, 32'h22, 0, 0);
    chk("pp level0", level, 3);
    chk("pp head0", m_tdata, 32'h20);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 32'h23 + i, 0, 1);
      chk($sformatf("pp%0d level", i), level, 3);
      chk($sformatf("pp%0d m_tdata", i), m_tdata, 32'h21 + i);
    end
    cyc(0, 0, 0, 1);
    chk("pp drain0", m_tdata, 32'h2B);
    cyc(0, 0, 0, 1);
    chk("pp drain1", m_tdata, 32'h2C);
    cyc(0, 0, 0, 1);
    chk("pp empty", m_tvalid, 0);
    chk("pp beat_cnt", beat_cnt, 26);

    // clear at level 4 with overflow set and a tlast head ready to pop.
    cyc(1, 32'h70, 1, 0);
    cyc(1, 32'h71, 0, 0);
    cyc(1, 32'h72, 0, 0);
    cyc(1, 32'h73, 0, 0);
    chk("clr pre level", level, 4);
    chk("clr pre overflow", overflow, 1);
    clear = 1'b1;
    s_tvalid = 1'b1;
    s_tdata = 32'h74;
    s_tlast = 1'b0;
    m_tready = 1'b1;
    #1;
    chk("clr s_tready", s_tready, 0);
    @(posedge axis_clk);
    #1;
    chk("clr level", level, 0);
    chk("clr m_tvalid", m_tvalid, 0);
    chk("clr beat_cnt", beat_cnt, 0);
    chk("clr frame_cnt", frame_cnt, 0);
    chk("clr overflow", overflow, 0);
    chk("clr frame_done", frame_done, 0);
    chk("clr state", dut.state_q, ST_IDLE);
    clear = 1'b0;
    cyc(0, 0, 0, 1);
    chk("clr+1 frame_done", frame_done, 0);
    chk("clr+1 level", level, 0);
    chk("clr+1 s_tready", s_tready, 1);

    // Back-to-back frames: second frame's first beat arrives as the first tlast pops.
    cyc(1, 32'h31, 0, 0);
    cyc(1, 32'h32, 0, 0);
    cyc(1, 32'h33, 1, 0);
    chk("b2b state tail", dut.state_q, ST_TAIL);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("b2b head 33", m_tdata, 32'h33);
    chk("b2b head tlast", m_tlast, 1);
    cyc(1, 32'h41, 0, 1);
    chk("b2b state active", dut.state_q, ST_ACTIVE);
    chk("b2b frame_done1", frame_done, 1);
    chk("b2b frame_cnt1", frame_cnt, 1);
    chk("b2b head 41", m_tdata, 32'h41);
    chk("b2b level", level, 1);
    cyc(1, 32'h42, 0, 1);
    chk("b2b head 42", m_tdata, 32'h42);
    chk("b2b frame_done off", frame_done, 0);
    cyc(1, 32'h43, 1, 1);
    chk("b2b head 43", m_tdata, 32'h43);
    chk("b2b state tail2", dut.state_q, ST_TAIL);
    cyc(0, 0, 0, 1);
    chk("b2b frame_done2", frame_done, 1);
    chk("b2b frame_cnt2", frame_cnt, 2);
    chk("b2b state idle", dut.state_q, ST_IDLE);
    chk("b2b empty", m_tvalid, 0);

    // Asynchronous reset mid-frame.
    cyc(1, 32'h51, 0, 0);
    cyc(1, 32'h52, 0, 0);
    s_tvalid = 1'b0;
    axis_rst_n = 1'b0;
    #1;
    chk("arst m_tvalid", m_tvalid, 0);
    chk("arst m_tdata", m_tdata, 0);
    chk("arst level", level, 0);
    chk("arst beat_cnt", beat_cnt, 0);
    chk("arst frame_cnt", frame_cnt, 0);
    chk("arst s_tready", s_tready, 0);
    @(posedge axis_clk);
    #1;
    axis_rst_n = 1'b1;
    cyc(0, 0, 0, 1);
    chk("arst+1 s_tready", s_tready, 1);
    chk("arst+1 m_tvalid", m_tvalid, 0);
    cyc(1, 32'h61, 0, 1);
    chk("arst f m_tdata0", m_tdata, 32'h61);
    chk("arst f m_tvalid0", m_tvalid, 1);
    cyc(1, 32'h62, 1, 1);
    chk("arst f m_tdata1", m_tdata, 32'h62);
    chk("arst f m_tlast1", m_tlast, 1);
    cyc(0, 0, 0, 1);
    chk("arst f frame_done", frame_done, 1);
    chk("arst f frame_cnt", frame_cnt, 1);
    chk("arst f beat_cnt", beat_cnt, 2);
    chk("arst f empty", m_tvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
